// File: rtl/pool_2_if.sv
// BRAM-side bus of the second max-pooling stage: a read port into the conv-2
// feature-map memory and a write port into the pooled-map memory.
interface pool_2_if #(
    parameter int DW     = 16,
    parameter int IN_AW  = 11,
    parameter int OUT_AW = 9
);
    logic              in_bram_en;
    logic [IN_AW-1:0]  in_bram_addr;
    logic [DW-1:0]     in_bram_dout;
    logic              out_bram_we;
    logic [OUT_AW-1:0] out_bram_addr;
    logic [DW-1:0]     out_bram_din;

    // Pooling engine side: drives both address ports, consumes read data.
    modport master (
        output in_bram_en, in_bram_addr,
        output out_bram_we, out_bram_addr, out_bram_din,
        input  in_bram_dout
    );

    // Memory side: answers reads, accepts writes.
    modport slave (
        input  in_bram_en, in_bram_addr,
        input  out_bram_we, out_bram_addr, out_bram_din,
        output in_bram_dout
    );
endinterface

// File: rtl/pool_2.sv
// pool_2: 2x2 stride-2 signed max pooling over MAPS maps of IN_DIM x IN_DIM.
// One input read per cycle (window-major, 4 reads per window); the pooled
// value of each window is written one cycle after its fourth sample returns.
module pool_2 #(
    parameter int DW     = 16,
    parameter int MAPS   = 16,
    parameter int IN_DIM = 10,
    parameter int IN_AW  = 11,
    parameter int OUT_AW = 9
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    pool_2_if.master bram,
    output logic     pool_2_finish
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CW_D    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int CW_M    = (MAPS > 1) ? $clog2(MAPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    // Window counters describe the read currently presented on the bus.
    logic [1:0]      r_phase, w_phase_nxt;
    logic [CW_D-1:0] r_j, w_j_nxt;
    logic [CW_D-1:0] r_i, w_i_nxt;
    logic [CW_M-1:0] r_m, w_m_nxt;
    logic            r_drain, w_drain_nxt;
    logic            w_rd_issue;
    logic            w_last;

    // Registered outputs.
    logic              r_rd_en;
    logic [IN_AW-1:0]  r_rd_addr;
    logic              r_we;
    logic [OUT_AW-1:0] r_wr_addr;
    logic [DW-1:0]     r_din;
    logic              r_finish;

    // Datapath state.
    logic                 r_rd_vld;
    logic [1:0]           r_rd_tag;
    logic signed [DW-1:0] r_max;
    logic [OUT_AW-1:0]    r_wr_idx;
    logic signed [DW-1:0] w_dout;
    logic signed [DW-1:0] w_max;

    // Linear input address of sample p of window (m, i, j).
    function automatic logic [IN_AW-1:0] calc_addr(
        input logic [CW_M-1:0] m,
        input logic [CW_D-1:0] i,
        input logic [CW_D-1:0] j,
        input logic [1:0]      p
    );
        int row;
        int col;
        int lin;
        row = 2 * int'(i) + int'(p[1]);
        col = 2 * int'(j) + int'(p[0]);
        lin = int'(m) * IN_DIM * IN_DIM + row * IN_DIM + col;
        return IN_AW'(lin);
    endfunction

    assign w_last = (r_phase == 2'd3) &&
                    (r_j == CW_D'(OUT_DIM - 1)) &&
                    (r_i == CW_D'(OUT_DIM - 1)) &&
                    (r_m == CW_M'(MAPS - 1));

    // State and counter register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses <=, so every register samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_j     <= '0;
            r_i     <= '0;
            r_m     <= '0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_j     <= w_j_nxt;
            r_i     <= w_i_nxt;
            r_m     <= w_m_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Next-state and read-sequencing logic.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_j_nxt     = r_j;
        w_i_nxt     = r_i;
        w_m_nxt     = r_m;
        w_drain_nxt = r_drain;
        w_rd_issue  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_READ;
                    w_phase_nxt = '0;
                    w_j_nxt     = '0;
                    w_i_nxt     = '0;
                    w_m_nxt     = '0;
                    w_rd_issue  = 1'b1;
                end
            end
            S_READ: begin
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                    w_phase_nxt = '0;
                    w_j_nxt     = '0;
                    w_i_nxt     = '0;
                    w_m_nxt     = '0;
                    w_drain_nxt = 1'b0;
                end else begin
                    w_rd_issue  = 1'b1;
                    w_phase_nxt = r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        if (r_j == CW_D'(OUT_DIM - 1)) begin
                            w_j_nxt = '0;
                            if (r_i == CW_D'(OUT_DIM - 1)) begin
                                w_i_nxt = '0;
                                w_m_nxt = r_m + CW_M'(1);
                            end else begin
                                w_i_nxt = r_i + CW_D'(1);
                            end
                        end else begin
                            w_j_nxt = r_j + CW_D'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Two cycles: last sample returns, then the last write lands.
                if (r_drain) begin
                    w_state_nxt = S_DONE;
                    w_drain_nxt = 1'b0;
                end else begin
                    w_drain_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read port and finish pulse, registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_finish  <= 1'b0;
        end else begin
            r_rd_en  <= w_rd_issue;
            r_finish <= (w_state_nxt == S_DONE);
            if (w_rd_issue) begin
                r_rd_addr <= calc_addr(w_m_nxt, w_i_nxt, w_j_nxt, w_phase_nxt);
            end
        end
    end

    assign w_dout = bram.in_bram_dout;

    // Running maximum: a tag-0 sample opens a new window.
    always_comb begin
        w_max = w_dout;
        if ((r_rd_tag != 2'd0) && (r_max > w_dout)) begin
            w_max = r_max;
        end
    end

    // Phase tag pipeline, max accumulation and pooled-map writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_tag  <= '0;
            r_max     <= '0;
            r_we      <= 1'b0;
            r_wr_addr <= '0;
            r_din     <= '0;
            r_wr_idx  <= '0;
        end else begin
            // Read data arrives one cycle after the request, so the tag
            // trails the bus by one cycle to line up with in_bram_dout.
            r_rd_vld <= r_rd_en;
            r_rd_tag <= r_phase;
            r_we     <= 1'b0;
            if ((r_state == S_IDLE) && start) begin
                r_wr_idx <= '0;
            end
            if (r_rd_vld) begin
                r_max <= w_max;
                if (r_rd_tag == 2'd3) begin
                    r_we      <= 1'b1;
                    r_din     <= w_max;
                    r_wr_addr <= r_wr_idx;
                    r_wr_idx  <= r_wr_idx + OUT_AW'(1);
                end
            end
        end
    end

    assign bram.in_bram_en   = r_rd_en;
    assign bram.in_bram_addr = r_rd_addr;
    assign bram.out_bram_we  = r_we;
    assign bram.out_bram_addr = r_wr_addr;
    assign bram.out_bram_din = r_din;
    assign pool_2_finish     = r_finish;

endmodule

// File: tb/tb_pool_2.sv
// Bench for pool_2: BRAM models on both ports, a scoreboard of expected
// writes (address, value, edge) and a negedge monitor that pops and compares.
// Edge numbering: cyc counts rising edges; a value seen at the negedge
// following edge e was registered at edge e.
module tb_pool_2;
    localparam int DW      = 16;
    localparam int MAPS    = 16;
    localparam int IN_DIM  = 10;
    localparam int IN_AW   = 11;
    localparam int OUT_AW  = 9;
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int N       = MAPS * OUT_DIM * OUT_DIM;
    localparam int LAT     = 4 * N + 2;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic pool_2_finish;

    pool_2_if #(.DW(DW), .IN_AW(IN_AW), .OUT_AW(OUT_AW)) bram_if ();

    pool_2 #(
        .DW(DW), .MAPS(MAPS), .IN_DIM(IN_DIM), .IN_AW(IN_AW), .OUT_AW(OUT_AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bram          (bram_if),
        .pool_2_finish (pool_2_finish)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_in   [0:2047];
    logic [DW-1:0] mem_out  [0:511];
    logic [DW-1:0] mem_snap [0:511];
    int cyc = 0;

    // Synchronous BRAMs: one-cycle read latency, write on the edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_if.in_bram_en) bram_if.in_bram_dout <= mem_in[bram_if.in_bram_addr];
        if (bram_if.out_bram_we) mem_out[bram_if.out_bram_addr] <= bram_if.out_bram_din;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        int            wr_edge;
    } exp_t;
    exp_t sb_q[$];

    // Reference: signed max of the 2x2 window behind pooled index k.
    function automatic logic [DW-1:0] pool_ref(input int k);
        int m, r, i, j, base;
        int offs [3];
        logic signed [DW-1:0] best, v;
        offs = '{1, IN_DIM, IN_DIM + 1};
        m    = k / (OUT_DIM * OUT_DIM);
        r    = k % (OUT_DIM * OUT_DIM);
        i    = r / OUT_DIM;
        j    = r % OUT_DIM;
        base = m * IN_DIM * IN_DIM + 2 * i * IN_DIM + 2 * j;
        best = mem_in[base];
        for (int q = 0; q < 3; q++) begin
            v = mem_in[base + offs[q]];
            if (v > best) best = v;
        end
        return best;
    endfunction

    task automatic push_run(input int s);
        for (int k = 0; k < N; k++) begin
            exp_t e;
            e.addr    = k;
            e.data    = pool_ref(k);
            e.wr_edge = s + 4 * k + 5;
            sb_q.push_back(e);
        end
    endtask

    int wr_cnt        = 0;
    int fin_cnt       = 0;
    int fin_edge      = -1;
    int first_rd_edge = -1;
    int max_rd_addr   = -1;
    bit we_q          = 1'b0;

    // Monitor: read tracking, scoreboard compare on each write, finish capture.
    always @(negedge clk) begin
        exp_t e;
        if (bram_if.in_bram_en === 1'b1) begin
            if (first_rd_edge < 0) first_rd_edge = cyc;
            if (int'(bram_if.in_bram_addr) > max_rd_addr) max_rd_addr = int'(bram_if.in_bram_addr);
        end
        if (bram_if.out_bram_we === 1'b1) begin
            wr_cnt++;
            check("we_not_back_to_back", we_q, 0);
            check("write_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("wr_addr", bram_if.out_bram_addr, e.addr);
                check("wr_data", $signed(bram_if.out_bram_din), $signed(e.data));
                check("wr_edge", cyc, e.wr_edge);
            end
        end
        we_q = (bram_if.out_bram_we === 1'b1);
        if (pool_2_finish === 1'b1) begin
            fin_cnt++;
            fin_edge = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_en"},    bram_if.in_bram_en, 0);
        check({tag, "_in_addr"},  bram_if.in_bram_addr, 0);
        check({tag, "_out_we"},   bram_if.out_bram_we, 0);
        check({tag, "_out_addr"}, bram_if.out_bram_addr, 0);
        check({tag, "_out_din"},  bram_if.out_bram_din, 0);
        check({tag, "_finish"},   pool_2_finish, 0);
    endtask

    // Drive start for one sampling edge (s = that edge) and queue expectations.
    task automatic begin_run(output int s);
        wr_cnt        = 0;
        fin_cnt       = 0;
        fin_edge      = -1;
        first_rd_edge = -1;
        max_rd_addr   = -1;
        start = 1'b1;
        s = cyc + 1;
        push_run(s);
        tick();
        start = 1'b0;
    endtask

    // Wait for finish; optionally pulse start so it is sampled at edges sp0/sp1.
    task automatic wait_finish(input string tag, input int sp0, input int sp1);
        for (int t = 0; t < LAT + 100 && fin_cnt == 0; t++) begin
            start = (cyc == sp0 - 1) || (cyc == sp1 - 1);
            tick();
        end
        start = 1'b0;
        check({tag, "_finish_seen"}, fin_cnt, 1);
    endtask

    int s_a, s_b, s_c, s_d, diffs;

    initial begin
        for (int a = 0; a < 2048; a++) mem_in[a] = DW'(a);

        // Reset state.
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Run A: ramp, with stray starts sampled at S+10 and S+1601.
        begin_run(s_a);
        wait_finish("A", s_a + 10, s_a + 1601);
        check("A_latency", fin_edge - s_a, LAT);
        check("A_first_read_edge", first_rd_edge, s_a);
        check("A_writes", wr_cnt, N);
        check("A_sb_empty", sb_q.size(), 0);
        check("A_max_read_addr", max_rd_addr, MAPS * IN_DIM * IN_DIM - 1);
        check("A_out0",   mem_out[0], 11);
        check("A_out1",   mem_out[1], 13);
        check("A_out24",  mem_out[24], 99);
        check("A_out25",  mem_out[25], 111);
        check("A_out399", mem_out[399], 1599);
        for (int k = 0; k < N; k++) mem_snap[k] = mem_out[k];

        // Start raised during the finish cycle (ignored) and held one more
        // cycle (accepted once IDLE): run B back to back with identical data.
        start = 1'b1;
        tick();
        check("A_finish_one_cycle", pool_2_finish, 0);
        begin_run(s_b);
        wait_finish("B", -1, -1);
        // En registered at the start-sampling edge: the BRAM takes the first
        // read on the following edge, one cycle after start.
        check("B_first_read_edge", first_rd_edge, s_b);
        check("B_latency", fin_edge - s_b, LAT);
        check("B_writes", wr_cnt, N);
        diffs = 0;
        for (int k = 0; k < N; k++) if (mem_out[k] !== mem_snap[k]) diffs++;
        check("B_same_as_A", diffs, 0);

        // Run C: reset sampled at S+700 aborts the run.
        repeat (3) tick();
        begin_run(s_c);
        for (int t = 0; t < LAT && cyc < s_c + 699; t++) tick();
        rst = 1'b1;
        tick();
        check_outputs_zero("abort");
        rst = 1'b0;
        sb_q.delete();
        check("C_writes_before_reset", wr_cnt, 174);
        repeat (30) tick();
        check("C_no_finish", fin_cnt, 0);
        check("C_no_write_after_reset", wr_cnt, 174);
        check("C_no_read_after_reset", bram_if.in_bram_en, 0);

        // Run D: fresh start with hand-built corner windows in map 0.
        mem_in[0]  = 16'hFFFB; mem_in[1]  = 16'h8000; mem_in[10] = 16'hFFFF; mem_in[11] = 16'hFFF9;
        mem_in[2]  = 16'h7FFF; mem_in[3]  = 16'h8000; mem_in[12] = 16'h0000; mem_in[13] = 16'h0001;
        mem_in[4]  = 16'hFFFD; mem_in[5]  = 16'hFFFD; mem_in[14] = 16'hFFFD; mem_in[15] = 16'hFFFD;
        begin_run(s_d);
        wait_finish("D", -1, -1);
        check("D_latency", fin_edge - s_d, LAT);
        check("D_writes", wr_cnt, N);
        check("D_sb_empty", sb_q.size(), 0);
        check("D_all_negative", $signed(mem_out[0]), -1);
        check("D_mixed_extremes", $signed(mem_out[1]), 32767);
        check("D_all_equal", $signed(mem_out[2]), -3);
        check("D_ramp_window", $signed(mem_out[3]), 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pool_2.md
# pool_2

Second max-pooling stage of the LeNet datapath, directly downstream of the second convolution stage. On a start pulse (driven by the convolution stage's finish flag), it reads the conv-2 output feature-map BRAM. It computes 2x2, stride-2 signed max pooling over every map and writes the pooled maps to its own output BRAM. It then pulses `pool_2_finish` to launch the next layer.

## Interface
Parameters:
- DW, 16: signed fixed-point data width.
- MAPS, 16: number of feature maps.
- IN_DIM, 10: input map side (even); output side is OUT_DIM = IN_DIM/2.
- IN_AW, 11: input BRAM address width (≥ clog2(MAPS·IN_DIM²)).
- OUT_AW, 9: output BRAM address width (≥ clog2(MAPS·OUT_DIM²)).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level/pulse; sampled only in IDLE.
- in_bram_en  out  1  input BRAM read enable.
- in_bram_addr  out  IN_AW  input address = m·IN_DIM² + r·IN_DIM + c.
- in_bram_dout  in  DW  read data, valid the cycle after en/addr.
- out_bram_we  out  1  output BRAM write enable.
- out_bram_addr  out  OUT_AW  output address = m·OUT_DIM² + i·OUT_DIM + j.
- out_bram_din  out  DW  pooled value.
- pool_2_finish  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE → READ when start=1; otherwise stay.
- READ: issues one read per cycle (in_bram_en=1) over counters phase (0..3, fastest), j, i, m (slowest).
  - Address for phase p: row 2i+p[1], column 2j+p[0].
  - After the last address (m=MAPS-1, i=j=OUT_DIM-1, p=3), go to DRAIN.
- DRAIN: stays for 2 cycles while the last data returns and the last write completes, then goes to DONE.
- DONE: asserts pool_2_finish for exactly 1 cycle, then returns to IDLE.
- Datapath: a phase tag is delayed 1 cycle alongside each read.
  - When data returns with tag 0, max_reg ← dout.
  - With any other tag, max_reg ← signed max(max_reg, dout).
  - Comparison is signed, DW bits; no saturation or ReLU. Ties keep either value, since they are equal.
- Write: the cycle after tag-3 data returns, out_bram_we=1 with out_bram_din=max_reg and out_bram_addr = the pooled index of that window. Pooled index increments 0..MAPS·OUT_DIM²-1.
- start while not IDLE is ignored.
- A new start in the same cycle as the pool_2_finish pulse is ignored; it is accepted once back in IDLE.

## Timing
- Reset values: in_bram_en=0, in_bram_addr=0, out_bram_we=0, out_bram_addr=0, out_bram_din=0, pool_2_finish=0, FSM=IDLE, all counters and max_reg 0.
- All outputs are registered.
- start high at edge S → first read at cycle S+1.
- Reads in cycles S+1..S+4N, with N = MAPS·OUT_DIM²; defaults give 4N=1600.
- Write k (k = 0..N-1) at cycle S+4k+5; the last write is at S+4N+1.
- pool_2_finish at cycle S+4N+2.
- Total latency start→finish is 4N+2 cycles (1602 with defaults).
- out_bram_we is high exactly N cycles per run, 1 of every 4 cycles, never back-to-back.
- rst asserted mid-run: the next cycle returns all outputs to reset values. No further reads or writes occur, and no finish pulse.
- Counter wrap: j wraps at OUT_DIM-1 into i; i wraps into m. No addresses beyond MAPS·IN_DIM²-1 are ever issued.

## Test plan
- Ramp input (address a holds value a) with defaults:
  - out[0]=11, out[1]=13, out[24]=99 (map 0), out[25]=111, out[399]=1599.
  - Exactly 400 writes.
  - Finish 1602 cycles after start.
- All-negative window, e.g. values -5, -32768, -1, -7 → written value -1.
- Mixed window 32767, -32768, 0, 1 → 32767; window of four equal -3 → -3.
- start pulsed again at cycles S+10 and S+1601 → ignored; exactly one finish pulse and 400 writes.
- rst asserted at cycle S+700 for 1 cycle:
  - All outputs 0 next cycle, no finish pulse.
  - A fresh start afterwards produces a complete correct run from out address 0.
- Back-to-back runs (start re-asserted the cycle after finish):
  - The second run's first read occurs 1 cycle after its start.
  - Identical output contents both runs.
